// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state/owner encodings and sizing helper shared by the RAM arbiter.
// Rev 1.0
`default_nettype none

package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational winner selection between fetch and load/store.
// Rev 1.0
`default_nettype none

module mem_arb_pick #(
  parameter int unsigned MAX_LS_STREAK = 2,
  parameter int unsigned STREAK_W      = 2
) (
  input  logic                if_req_i,
  input  logic                ls_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_if_o,
  output logic                grant_ls_o
);

  logic w_streak_full;

  assign w_streak_full = (streak_i == STREAK_W'(MAX_LS_STREAK));

  // LS is preferred until it has starved a waiting fetch MAX_LS_STREAK times.
  always_comb begin
    grant_if_o = if_req_i & (~ls_req_i | w_streak_full);
    grant_ls_o = ls_req_i & (~if_req_i | ~w_streak_full);
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch and load/store requesters.
// Rev 1.0
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_LATENCY   = 1,
  parameter int unsigned MAX_LS_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);

  localparam int unsigned LAT_W    = cnt_width(RAM_LATENCY - 1);
  localparam int unsigned STREAK_W = cnt_width(MAX_LS_STREAK);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;

  logic w_grant_if;
  logic w_grant_ls;
  logic w_idle;

  mem_arb_pick #(
    .MAX_LS_STREAK (MAX_LS_STREAK),
    .STREAK_W      (STREAK_W)
  ) u_pick (
    .if_req_i   (if_req_i),
    .ls_req_i   (ls_req_i),
    .streak_i   (streak_q),
    .grant_if_o (w_grant_if),
    .grant_ls_o (w_grant_ls)
  );

  assign w_idle = (state_q == ARB_IDLE);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (w_grant_if || w_grant_ls) begin
          owner_d    = w_grant_ls ? OWN_LS : OWN_IF;
          mem_addr_d = w_grant_ls ? ls_addr_i : if_addr_i;
          mem_we_d   = w_grant_ls & ls_we_i;
          if (w_grant_ls && ls_we_i) begin
            mem_data_d = ls_wdata_i;
          end
          lat_d   = LAT_W'(RAM_LATENCY - 1);
          state_d = ARB_ACCESS;
          // Streak only grows while a fetch is actually being held off.
          if (w_grant_ls && if_req_i) begin
            streak_d = (streak_q == STREAK_W'(MAX_LS_STREAK)) ? streak_q
                                                               : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end
      end

      ARB_ACCESS: begin
        if (lat_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d  = mem_data_i;
            if_rvalid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              ls_rdata_d = mem_data_i;
            end
            ls_rvalid_d = 1'b1;
          end
          mem_we_d = 1'b0;
          state_d  = ARB_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      streak_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign if_gnt_o    = w_idle & w_grant_if;
  assign ls_gnt_o    = w_idle & w_grant_ls;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign busy_o      = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model.
// Rev 1.0
`default_nettype none

module tb_mem_arbiter;

  localparam int LAT  = 1;
  localparam int MAXS = 2;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance with RAM_LATENCY=1
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wd, mem_rd;

  // Instance with RAM_LATENCY=3
  logic        if_req3, ls_req3, ls_we3;
  logic [31:0] if_addr3, ls_addr3, ls_wdata3;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_we3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wd3, mem_rd3;

  mem_arbiter #(.RAM_LATENCY(LAT), .MAX_LS_STREAK(MAXS)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wd),
    .mem_data_i(mem_rd), .busy_o(busy)
  );

  mem_arbiter #(.RAM_LATENCY(LAT3), .MAX_LS_STREAK(MAXS)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .ls_req_i(ls_req3), .ls_we_i(ls_we3), .ls_addr_i(ls_addr3), .ls_wdata_i(ls_wdata3),
    .ls_gnt_o(ls_gnt3), .ls_rvalid_o(ls_rvalid3), .ls_rdata_o(ls_rdata3),
    .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_data_o(mem_wd3),
    .mem_data_i(mem_rd3), .busy_o(busy3)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // RAM models: writes and reads resolve on the falling edge so data is settled at posedge.
  logic [31:0] ram1 [bit [31:0]];
  logic [31:0] ram3 [bit [31:0]];
  logic [31:0] prev_addr3 = 32'h0;
  int          stable3    = 100;
  int          we_cnt     = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      ram1[mem_addr] = mem_wd;
      we_cnt++;
    end
    mem_rd = ram1.exists(mem_addr) ? ram1[mem_addr] : init_word(mem_addr);
    if (mem_we3 === 1'b1) ram3[mem_addr3] = mem_wd3;
    if (mem_addr3 === prev_addr3) begin
      if (stable3 < 100) stable3++;
    end else begin
      stable3 = 0;
    end
    prev_addr3 = mem_addr3;
    // Data only becomes valid once the address has been held RAM_LATENCY cycles.
    mem_rd3 = (stable3 >= LAT3 - 1)
              ? (ram3.exists(mem_addr3) ? ram3[mem_addr3] : init_word(mem_addr3))
              : 32'hBAD0_BAD0;
  end

  // Reference model: transaction view of the latency-1 arbiter.
  logic [31:0] mref [bit [31:0]];
  int          m_busy;
  int          m_streak;
  bit          m_own_ls, m_we;
  logic [31:0] m_addr, m_data, m_if_rdata, m_ls_rdata;

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mref.exists(a) ? mref[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_streak = 0; m_own_ls = 1'b0; m_we = 1'b0;
      m_addr = '0; m_data = '0; m_if_rdata = '0; m_ls_rdata = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 1) begin
        if (!m_own_ls) m_if_rdata = mread(m_addr);
        else if (!m_we) m_ls_rdata = mread(m_addr);
        m_we = 1'b0;
      end
    end else if (if_req || ls_req) begin
      m_own_ls = ls_req && !(if_req && m_streak >= MAXS);
      m_busy   = LAT + 1;
      if (m_own_ls) begin
        m_addr = ls_addr;
        m_we   = ls_we;
        if (ls_we) begin
          m_data        = ls_wdata;
          mref[ls_addr] = ls_wdata;
        end
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else begin
        m_addr   = if_addr;
        m_we     = 1'b0;
        m_streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("if_gnt",    32'(if_gnt),    32'((m_busy == 0) && if_req && !(ls_req && m_streak < MAXS)));
      chk("ls_gnt",    32'(ls_gnt),    32'((m_busy == 0) && ls_req && !(if_req && m_streak >= MAXS)));
      chk("if_rvalid", 32'(if_rvalid), 32'((m_busy == 1) && !m_own_ls));
      chk("ls_rvalid", 32'(ls_rvalid), 32'((m_busy == 1) && m_own_ls));
      chk("busy",      32'(busy),      32'(m_busy != 0));
      chk("mem_we",    32'(mem_we),    32'(m_we));
      chk("mem_addr",  mem_addr,   m_addr);
      chk("mem_data",  mem_wd,     m_data);
      chk("if_rdata",  if_rdata,   m_if_rdata);
      chk("ls_rdata",  ls_rdata,   m_ls_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] a);
    bit ok = 1'b0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 30 && !ok; i++) begin
      #2;
      if (if_gnt === 1'b1) ok = 1'b1;
      else step();
    end
    if (!ok) chk("if_grant_timeout", 32'd0, 32'd1);
    step();
    if_req = 1'b0;
  endtask

  task automatic issue_ls(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
    for (int i = 0; i < 30 && !ok; i++) begin
      #2;
      if (ls_gnt === 1'b1) ok = 1'b1;
      else step();
    end
    if (!ok) chk("ls_grant_timeout", 32'd0, 32'd1);
    step();
    ls_req = 1'b0;
  endtask

  task automatic wait_rvalid(input bit is_ls, output logic [31:0] d);
    bit ok = 1'b0;
    d = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      #2;
      if (is_ls ? (ls_rvalid === 1'b1) : (if_rvalid === 1'b1)) begin
        ok = 1'b1;
        d  = is_ls ? ls_rdata : if_rdata;
      end
      step();
    end
    if (!ok) chk("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      #2;
      if (busy === 1'b0) ok = 1'b1;
      step();
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  int          g_who [6];
  int          g_cyc [6];
  int          exp_who [6];
  int          ng;
  int          we_before;
  logic [31:0] rd;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0; ls_req3 = 1'b0; ls_we3 = 1'b0; ls_addr3 = '0; ls_wdata3 = '0;
    mem_rd = '0; mem_rd3 = '0;
    exp_who = '{1, 1, 0, 1, 1, 0};
    repeat (3) step();
    reset  = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_busy",     32'(busy),   32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr,    32'h0);
    chk("rst_if_rdata", if_rdata,    32'h0);
    chk("rst_busy3",    32'(busy3),  32'd0);
    step();

    // Latency-3 load: address held three cycles, response on the fourth.
    ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h60;
    #2; chk("l3_gnt", 32'(ls_gnt3), 32'd1);
    step(); ls_req3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk("l3_busy",   32'(busy3),      32'd1);
      chk("l3_addr",   mem_addr3,       32'h60);
      chk("l3_rvalid", 32'(ls_rvalid3), 32'd0);
      step();
    end
    #2;
    chk("l3_rvalid_t4", 32'(ls_rvalid3), 32'd1);
    chk("l3_rdata",     ls_rdata3,       32'hA5A5_0060);
    step();
    #2;
    chk("l3_rvalid_off", 32'(ls_rvalid3), 32'd0);
    chk("l3_idle",       32'(busy3),      32'd0);
    step();

    // Fetch of 0x10 with latency 1.
    if_req = 1'b1; if_addr = 32'h10;
    #2; chk("t1_gnt", 32'(if_gnt), 32'd1); chk("t1_busy0", 32'(busy), 32'd0);
    step(); if_req = 1'b0;
    #2; chk("t1_addr", mem_addr, 32'h10); chk("t1_busy1", 32'(busy), 32'd1);
    step();
    #2; chk("t1_rvalid", 32'(if_rvalid), 32'd1); chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_busy2", 32'(busy), 32'd1);
    step();
    #2; chk("t1_idle", 32'(busy), 32'd0);
    step();

    // Store then load back.
    we_before = we_cnt;
    issue_ls(1'b1, 32'h20, 32'h1234_5678);
    wait_rvalid(1'b1, rd);
    wait_idle();
    chk("st_we_cycles", 32'(we_cnt - we_before), 32'd1);
    chk("st_rdata_kept", ls_rdata, 32'h0);
    issue_ls(1'b0, 32'h20, 32'h0);
    wait_rvalid(1'b1, rd);
    chk("ld_rdata", rd, 32'h1234_5678);
    wait_idle();

    // Both requesters held: LS, LS, IF repeating, one grant every three cycles.
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #2;
      if (if_gnt === 1'b1 || ls_gnt === 1'b1) begin
        g_who[ng] = (ls_gnt === 1'b1) ? 1 : 0;
        g_cyc[ng] = c;
        ng++;
      end
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("fair_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("fair_order", 32'(g_who[i]), 32'(exp_who[i]));
      if (i > 0) chk("fair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    wait_idle();

    // Reset during the access phase of a store.
    issue_ls(1'b1, 32'h30, 32'h55);
    reset = 1'b1;
    #2; chk("rm_we_access", 32'(mem_we), 32'd1);
    step(); reset = 1'b0;
    #2;
    chk("rm_we",     32'(mem_we),    32'd0);
    chk("rm_busy",   32'(busy),      32'd0);
    chk("rm_rvalid", 32'(ls_rvalid), 32'd0);
    step();
    #2; chk("rm_rvalid2", 32'(ls_rvalid), 32'd0);
    step();
    issue_if(32'h40);
    wait_rvalid(1'b0, rd);
    chk("rm_if_rdata", rd, 32'hA5A5_0040);
    wait_idle();

    // Fetch raised during RESP waits for the first IDLE cycle.
    issue_ls(1'b0, 32'h50, 32'h0);
    step();
    if_req = 1'b1; if_addr = 32'h70;
    #2;
    chk("resp_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("resp_no_gnt",    32'(if_gnt),    32'd0);
    step();
    #2; chk("idle_if_gnt", 32'(if_gnt), 32'd1);
    step(); if_req = 1'b0;
    wait_rvalid(1'b0, rd);
    chk("resp_if_rdata", rd, 32'hA5A5_0070);
    wait_idle();
    chk("ls_rdata_held", ls_rdata, 32'hA5A5_0050);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
